// File: rtl/divider_recon_checker_if.sv
// Sample-in / result-out channel of the divider reconstruction checker.
interface divider_recon_checker_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] n;
    logic [W-1:0]   d;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] n_rec;
    logic [2*W-1:0] abs_err;
    logic           err_neg;

    modport master (
        output in_valid, n, d, q, r, out_ready,
        input  in_ready, out_valid, n_rec, abs_err, err_neg
    );

    modport slave (
        input  in_valid, n, d, q, r, out_ready,
        output in_ready, out_valid, n_rec, abs_err, err_neg
    );
endinterface

// File: rtl/divider_recon_checker.sv
// Rebuilds n_rec = q*d + r with a shift-add multiplier and reports |n - n_rec| plus running stats.
// Latency: result valid W+1 edges after accept; one sample in flight, period W+3 with out_ready high.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module divider_recon_checker #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    divider_recon_checker_if.slave bus,
    input  logic                   clr,
    output logic [2*W-1:0]         err_max,
    output logic [CNT_W-1:0]       mismatch_cnt
);
    localparam int            KW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [2*W-1:0] nreg;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [W-1:0]   dreg;
    logic [W-1:0]   qreg;
    logic [KW-1:0]  k;
    logic [2*W-1:0] rec_err;
    logic           rec_neg;

    logic           out_valid_q;
    logic [2*W-1:0] n_rec_q;
    logic [2*W-1:0] abs_err_q;
    logic           err_neg_q;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.n_rec     = n_rec_q;
    assign bus.abs_err   = abs_err_q;
    assign bus.err_neg   = err_neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = MUL;
            MUL:     if (k == K_LAST) state_nxt = CMP;
            CMP:     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // (2^W-1)^2 + (2^W-1) fits in 2W bits, so the accumulator never carries out.
    always_comb begin
        acc_nxt = acc;
        if (qreg[0]) begin
            acc_nxt = acc + ({{W{1'b0}}, dreg} << k);
        end
        rec_neg = (acc > nreg);
        rec_err = rec_neg ? (acc - nreg) : (nreg - acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nreg        <= '0;
            dreg        <= '0;
            qreg        <= '0;
            acc         <= '0;
            k           <= '0;
            out_valid_q <= 1'b0;
            n_rec_q     <= '0;
            abs_err_q   <= '0;
            err_neg_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        nreg <= bus.n;
                        dreg <= bus.d;
                        qreg <= bus.q;
                        acc  <= {{W{1'b0}}, bus.r};
                        k    <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc_nxt;
                    qreg <= qreg >> 1;
                    k    <= k + 1'b1;
                end
                CMP: begin
                    n_rec_q     <= acc;
                    abs_err_q   <= rec_err;
                    err_neg_q   <= rec_neg;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear landing on the CMP edge discards that sample's contribution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_max      <= '0;
            mismatch_cnt <= '0;
        end else if (clr) begin
            err_max      <= '0;
            mismatch_cnt <= '0;
        end else if (state == CMP) begin
            if (rec_err > err_max) begin
                err_max <= rec_err;
            end
            if ((rec_err != '0) && (mismatch_cnt != '1)) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
        end
    end
endmodule
